// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the single-issue MIPS core front end.
//   - Primary opcode constants decoded by the control unit.
//   - Fetch FSM state encoding (2 bits: IDLE, FETCH, EXEC).
//   - Default PC loaded on reset.
//   - Helper that builds the byte offset of a beq from its 16-bit immediate.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  // Word offset in the immediate becomes a sign-extended byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational next-PC selection for the fetch unit.
// Ports:
//   PC_PLUS4  in  32  address of the instruction after the current one
//   INSTR     in  32  current instruction (jump index / branch immediate)
//   PC_SRC    in  1   take the beq target
//   JUMP      in  1   take the j target (wins over PC_SRC)
//   NEXT_PC   out 32  address to fetch next
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] PC_PLUS4,
  input  logic [31:0] INSTR,
  input  logic        PC_SRC,
  input  logic        JUMP,
  output logic [31:0] NEXT_PC
);

  // The opcode field is not needed here; the control unit has already decoded it.
  logic unusedOpcode;
  assign unusedOpcode = ^INSTR[31:26];

  // JUMP is checked first because the control unit raises both PC_SRC and
  // JUMP for a j instruction. All additions wrap modulo 2^32.
  always_comb begin
    NEXT_PC = PC_PLUS4;
    if (JUMP) begin
      NEXT_PC = {PC_PLUS4[31:28], INSTR[25:0], 2'b00};
    end else if (PC_SRC) begin
      NEXT_PC = PC_PLUS4 + branch_offset(INSTR[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage: holds the PC, fetches one word per instruction over a
// req/ready handshake, and presents the latched instruction to the control
// unit. The control unit's PC_SRC/JUMP decision selects the next PC.
// Ports:
//   CLK, RST_N               clock (rising edge), async active-low reset
//   IMEM_REQ/IMEM_ADDR       fetch request and word-aligned byte address
//   IMEM_RDATA/IMEM_READY    returned word, valid when IMEM_READY=1
//   STALL                    hold the current instruction in EXEC
//   PC_SRC, JUMP             branch / jump decision from the control unit
//   INSTR, OPCODE, FUNCT     latched instruction and its decode fields
//   INSTR_VALID              INSTR is current; control outputs are sampled
//   PC, PC_PLUS4             address of INSTR and the following word
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_READY,
  input  logic        STALL,
  input  logic        PC_SRC,
  input  logic        JUMP,
  output logic [31:0] INSTR,
  output logic [5:0]  OPCODE,
  output logic [5:0]  FUNCT,
  output logic        INSTR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4
);

  // Low two bits of the reset PC are forced to zero to keep fetches aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  pcPlus4;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         valid_q;

  assign pcPlus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .PC_PLUS4 (pcPlus4),
    .INSTR    (instr_q),
    .PC_SRC   (PC_SRC),
    .JUMP     (JUMP),
    .NEXT_PC  (pc_d)
  );

  // Fetch FSM. IMEM_REQ and INSTR_VALID are registered alongside the state so
  // they are true Moore outputs; the async reset clears them immediately,
  // which aborts any outstanding fetch without touching the PC path.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        ST_FETCH: begin
          if (IMEM_READY) begin
            instr_q <= IMEM_RDATA;
            state_q <= ST_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (!STALL) begin
            pc_q    <= pc_d;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign OPCODE      = instr_q[31:26];
  assign FUNCT       = instr_q[5:0];
  assign INSTR_VALID = valid_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pcPlus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a hand-driven instruction memory.
// Each scenario task drives its own stimulus and checks outputs inline.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_READY;
  logic        STALL;
  logic        PC_SRC;
  logic        JUMP;
  logic [31:0] INSTR;
  logic [5:0]  OPCODE;
  logic [5:0]  FUNCT;
  logic        INSTR_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;

  int testsRun;
  int testsFailed;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_RDATA  (IMEM_RDATA),
    .IMEM_READY  (IMEM_READY),
    .STALL       (STALL),
    .PC_SRC      (PC_SRC),
    .JUMP        (JUMP),
    .INSTR       (INSTR),
    .OPCODE      (OPCODE),
    .FUNCT       (FUNCT),
    .INSTR_VALID (INSTR_VALID),
    .PC          (PC),
    .PC_PLUS4    (PC_PLUS4)
  );

  // 10 ns clock period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one cycle; returns 1 ns after the rising edge so outputs have
  // settled and new inputs are stable well before the next edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Answer the pending fetch with a zero-wait-state response, ending in EXEC.
  task automatic load_instr(input logic [31:0] data);
    IMEM_READY = 1'b1;
    IMEM_RDATA = data;
    tick();
    IMEM_READY = 1'b0;
    IMEM_RDATA = 32'hDEAD_BEEF;
  endtask

  // Let the EXEC cycle retire with the given control decision.
  task automatic retire(input logic pcSrc, input logic jump);
    PC_SRC = pcSrc;
    JUMP   = jump;
    tick();
    PC_SRC = 1'b0;
    JUMP   = 1'b0;
  endtask

  // Reset values, then one IDLE cycle, then the first fetch at RESET_PC.
  task automatic test_reset;
    RST_N = 1'b0;
    #3;
    testsRun++; if (IMEM_REQ !== 1'b0) begin $display("[TB] FAIL reset_req: got %b expected 0", IMEM_REQ); testsFailed++; end
    testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL reset_valid: got %b expected 0", INSTR_VALID); testsFailed++; end
    testsRun++; if (PC !== 32'h0) begin $display("[TB] FAIL reset_pc: got %h expected 00000000", PC); testsFailed++; end
    testsRun++; if (INSTR !== 32'h0) begin $display("[TB] FAIL reset_instr: got %h expected 00000000", INSTR); testsFailed++; end
    tick();
    tick();
    RST_N = 1'b1;
    testsRun++; if (IMEM_REQ !== 1'b0) begin $display("[TB] FAIL idle_req: got %b expected 0", IMEM_REQ); testsFailed++; end
    tick();
    testsRun++; if (IMEM_REQ !== 1'b1) begin $display("[TB] FAIL first_req: got %b expected 1", IMEM_REQ); testsFailed++; end
    testsRun++; if (IMEM_ADDR !== 32'h0) begin $display("[TB] FAIL first_addr: got %h expected 00000000", IMEM_ADDR); testsFailed++; end
    testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL first_valid: got %b expected 0", INSTR_VALID); testsFailed++; end
  endtask

  // addi at PC 0, then a sequential next PC.
  task automatic test_first_fetch;
    load_instr(32'h2008_0005);
    testsRun++; if (INSTR_VALID !== 1'b1) begin $display("[TB] FAIL addi_valid: got %b expected 1", INSTR_VALID); testsFailed++; end
    testsRun++; if (OPCODE !== 6'h08) begin $display("[TB] FAIL addi_opcode: got %h expected 08", OPCODE); testsFailed++; end
    testsRun++; if (FUNCT !== 6'h05) begin $display("[TB] FAIL addi_funct: got %h expected 05", FUNCT); testsFailed++; end
    testsRun++; if (IMEM_REQ !== 1'b0) begin $display("[TB] FAIL exec_req: got %b expected 0", IMEM_REQ); testsFailed++; end
    testsRun++; if (PC_PLUS4 !== 32'h4) begin $display("[TB] FAIL addi_pcplus4: got %h expected 00000004", PC_PLUS4); testsFailed++; end
    retire(1'b0, 1'b0);
    testsRun++; if (IMEM_ADDR !== 32'h4) begin $display("[TB] FAIL seq_addr: got %h expected 00000004", IMEM_ADDR); testsFailed++; end
    testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL seq_valid: got %b expected 0", INSTR_VALID); testsFailed++; end
  endtask

  // j 0x10 from PC 4, then beq -1 at PC 0x10 taken (loops) and not taken.
  task automatic test_beq;
    load_instr(32'h0800_0004);
    retire(1'b1, 1'b1);
    testsRun++; if (IMEM_ADDR !== 32'h10) begin $display("[TB] FAIL j_to_10: got %h expected 00000010", IMEM_ADDR); testsFailed++; end
    load_instr(32'h1000_FFFF);
    testsRun++; if (PC !== 32'h10) begin $display("[TB] FAIL beq_pc: got %h expected 00000010", PC); testsFailed++; end
    retire(1'b1, 1'b0);
    testsRun++; if (IMEM_ADDR !== 32'h10) begin $display("[TB] FAIL beq_taken: got %h expected 00000010", IMEM_ADDR); testsFailed++; end
    load_instr(32'h1000_FFFF);
    retire(1'b0, 1'b0);
    testsRun++; if (IMEM_ADDR !== 32'h14) begin $display("[TB] FAIL beq_not_taken: got %h expected 00000014", IMEM_ADDR); testsFailed++; end
  endtask

  // j 0x40 from 0x14, then j 0xC from 0x40 with both decisions raised.
  task automatic test_jump;
    load_instr(32'h0800_0010);
    retire(1'b1, 1'b1);
    testsRun++; if (IMEM_ADDR !== 32'h40) begin $display("[TB] FAIL j_to_40: got %h expected 00000040", IMEM_ADDR); testsFailed++; end
    load_instr(32'h0800_0003);
    testsRun++; if (OPCODE !== 6'h02) begin $display("[TB] FAIL j_opcode: got %h expected 02", OPCODE); testsFailed++; end
    retire(1'b1, 1'b1);
    testsRun++; if (IMEM_ADDR !== 32'hC) begin $display("[TB] FAIL j_to_c: got %h expected 0000000c", IMEM_ADDR); testsFailed++; end
  endtask

  // Three memory wait states, then two stalled EXEC cycles during which
  // READY and the control decisions are driven but must be ignored.
  task automatic test_wait_stall;
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (IMEM_REQ !== 1'b1) begin $display("[TB] FAIL wait_req[%0d]: got %b expected 1", i, IMEM_REQ); testsFailed++; end
      testsRun++; if (IMEM_ADDR !== 32'hC) begin $display("[TB] FAIL wait_addr[%0d]: got %h expected 0000000c", i, IMEM_ADDR); testsFailed++; end
      testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL wait_valid[%0d]: got %b expected 0", i, INSTR_VALID); testsFailed++; end
      tick();
    end
    load_instr(32'h8C09_0008);
    STALL      = 1'b1;
    PC_SRC     = 1'b1;
    JUMP       = 1'b1;
    IMEM_READY = 1'b1;
    IMEM_RDATA = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (INSTR_VALID !== 1'b1) begin $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, INSTR_VALID); testsFailed++; end
      testsRun++; if (INSTR !== 32'h8C09_0008) begin $display("[TB] FAIL stall_instr[%0d]: got %h expected 8c090008", i, INSTR); testsFailed++; end
      testsRun++; if (PC !== 32'hC) begin $display("[TB] FAIL stall_pc[%0d]: got %h expected 0000000c", i, PC); testsFailed++; end
      if (i == 2) begin
        STALL      = 1'b0;
        PC_SRC     = 1'b0;
        JUMP       = 1'b0;
        IMEM_READY = 1'b0;
      end
      tick();
    end
    testsRun++; if (IMEM_ADDR !== 32'h10) begin $display("[TB] FAIL stall_next_addr: got %h expected 00000010", IMEM_ADDR); testsFailed++; end
    testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL stall_exit_valid: got %b expected 0", INSTR_VALID); testsFailed++; end
  endtask

  // j 0 from 0x10, beq -2 at PC 0 lands on 0xFFFFFFFC, then a sequential
  // instruction there wraps back to 0.
  task automatic test_wrap;
    load_instr(32'h0800_0000);
    retire(1'b1, 1'b1);
    testsRun++; if (IMEM_ADDR !== 32'h0) begin $display("[TB] FAIL j_to_0: got %h expected 00000000", IMEM_ADDR); testsFailed++; end
    load_instr(32'h1000_FFFE);
    retire(1'b1, 1'b0);
    testsRun++; if (IMEM_ADDR !== 32'hFFFF_FFFC) begin $display("[TB] FAIL beq_back: got %h expected fffffffc", IMEM_ADDR); testsFailed++; end
    load_instr(32'h0000_0020);
    testsRun++; if (PC_PLUS4 !== 32'h0) begin $display("[TB] FAIL wrap_pcplus4: got %h expected 00000000", PC_PLUS4); testsFailed++; end
    retire(1'b0, 1'b0);
    testsRun++; if (IMEM_ADDR !== 32'h0) begin $display("[TB] FAIL wrap_addr: got %h expected 00000000", IMEM_ADDR); testsFailed++; end
  endtask

  // Advance to PC 4 with a nonzero INSTR, reset while the fetch is waiting,
  // then restart normally.
  task automatic test_reset_mid_fetch;
    load_instr(32'h2008_FFFF);
    retire(1'b0, 1'b0);
    tick();
    testsRun++; if (IMEM_REQ !== 1'b1) begin $display("[TB] FAIL pre_reset_req: got %b expected 1", IMEM_REQ); testsFailed++; end
    #2;
    RST_N = 1'b0;
    #1;
    testsRun++; if (IMEM_REQ !== 1'b0) begin $display("[TB] FAIL abort_req: got %b expected 0", IMEM_REQ); testsFailed++; end
    testsRun++; if (PC !== 32'h0) begin $display("[TB] FAIL abort_pc: got %h expected 00000000", PC); testsFailed++; end
    testsRun++; if (INSTR !== 32'h0) begin $display("[TB] FAIL abort_instr: got %h expected 00000000", INSTR); testsFailed++; end
    testsRun++; if (INSTR_VALID !== 1'b0) begin $display("[TB] FAIL abort_valid: got %b expected 0", INSTR_VALID); testsFailed++; end
    tick();
    RST_N = 1'b1;
    testsRun++; if (IMEM_REQ !== 1'b0) begin $display("[TB] FAIL restart_idle_req: got %b expected 0", IMEM_REQ); testsFailed++; end
    tick();
    testsRun++; if (IMEM_REQ !== 1'b1) begin $display("[TB] FAIL restart_req: got %b expected 1", IMEM_REQ); testsFailed++; end
    testsRun++; if (IMEM_ADDR !== 32'h0) begin $display("[TB] FAIL restart_addr: got %h expected 00000000", IMEM_ADDR); testsFailed++; end
    load_instr(32'h012A_4020);
    testsRun++; if (FUNCT !== 6'h20) begin $display("[TB] FAIL restart_funct: got %h expected 20", FUNCT); testsFailed++; end
    testsRun++; if (OPCODE !== 6'h00) begin $display("[TB] FAIL restart_opcode: got %h expected 00", OPCODE); testsFailed++; end
  endtask

  // Scenario sequence; each task leaves the DUT where the next expects it.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    RST_N       = 1'b0;
    IMEM_RDATA  = 32'h0;
    IMEM_READY  = 1'b0;
    STALL       = 1'b0;
    PC_SRC      = 1'b0;
    JUMP        = 1'b0;
    test_reset();
    test_first_fetch();
    test_beq();
    test_jump();
    test_wait_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-issue MIPS core, directly upstream of the control unit. Holds the program counter and issues word fetches to instruction memory over a req/ready handshake. Presents the latched instruction, with its OPCODE/FUNCT fields, to the control unit. Consumes the control unit's PC_SRC/JUMP decisions to select the next PC (sequential, beq target, or j target).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] ignored (forced 0)

Ports:
- CLK  in  1  core clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IMEM_REQ  out  1  fetch request to instruction memory
- IMEM_ADDR  out  32  fetch byte address (= PC, bits [1:0] always 0)
- IMEM_RDATA  in  32  fetched instruction word, valid when IMEM_READY=1
- IMEM_READY  in  1  memory accepts request and returns data this cycle
- STALL  in  1  hold current instruction in EXEC (no PC update)
- PC_SRC  in  1  from control unit: take branch target
- JUMP  in  1  from control unit: take jump target
- INSTR  out  32  latched instruction register
- OPCODE  out  6  INSTR[31:26]
- FUNCT  out  6  INSTR[5:0]
- INSTR_VALID  out  1  INSTR is current and the control outputs are to be sampled
- PC  out  32  address of INSTR
- PC_PLUS4  out  32  PC + 4

## Operation
- FSM states: IDLE, FETCH, EXEC. All outputs are Moore/registered; IMEM_REQ = (state==FETCH); INSTR_VALID = (state==EXEC).
- IDLE: entered on reset; unconditional transition to FETCH on the next clock.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable. When IMEM_READY=1: INSTR <= IMEM_RDATA, go to EXEC. Otherwise remain in FETCH (wait states are unbounded).
- EXEC: INSTR_VALID=1. If STALL=1: hold state, PC, INSTR. If STALL=0: PC <= next_pc, go to FETCH.
- next_pc priority:
  - JUMP=1: {PC_PLUS4[31:28], INSTR[25:0], 2'b00}
  - else PC_SRC=1: PC_PLUS4 + {{14{INSTR[15]}}, INSTR[15:0], 2'b00}
  - else: PC_PLUS4
- JUMP has priority because the control unit drives PC_SRC=JUMP=1 for j.
- All PC arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- IMEM_READY is ignored outside FETCH. STALL is ignored outside EXEC. PC_SRC/JUMP are sampled only on the EXEC cycle with STALL=0.
- Reset values: state=IDLE, PC=RESET_PC & ~3, INSTR=0 (OPCODE=0, FUNCT=0, which decodes to the control unit's no-op default), IMEM_REQ=0, INSTR_VALID=0.
- Reset asserted mid-FETCH or mid-EXEC: the fetch is aborted immediately (IMEM_REQ drops asynchronously) and no PC update occurs. Memory must tolerate a dropped request.

## Timing
- After RST_N deassertion: edge 1 enters FETCH, so IMEM_REQ=1 in the second cycle.
- Zero-wait memory: one instruction per 2 cycles (FETCH, EXEC). Each memory wait state adds 1 cycle.
- INSTR/OPCODE/FUNCT are valid from the cycle after the IMEM_READY handshake until the edge leaving EXEC.
- The control unit is combinational, so PC_SRC/JUMP must settle within the EXEC cycle. The next IMEM_ADDR appears in the following cycle.

## Structure
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=6'b000000, OP_ADDI=6'b001000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010
  - FSM state encoding (IDLE/FETCH/EXEC, 2 bits)
  - DEFAULT_RESET_PC
- One combinational sub-module next_pc_calc (inputs PC_PLUS4, INSTR, PC_SRC, JUMP; output next_pc). The FSM and registers stay in the top level.

## Test plan
- Reset/first fetch: RESET_PC=0, release RST_N → IMEM_REQ=0 for 1 cycle, then IMEM_REQ=1 with IMEM_ADDR=0. READY with RDATA=0x20080005 → INSTR_VALID=1, OPCODE=0x08. PC_SRC=JUMP=0 → next IMEM_ADDR=0x4.
- beq taken: PC=0x10, INSTR=0x1000FFFF, PC_SRC=1, JUMP=0 → next IMEM_ADDR=0x10. Same instruction with PC_SRC=0 → 0x14.
- j: PC=0x40, INSTR=0x08000003, PC_SRC=1, JUMP=1 → next IMEM_ADDR=0x0000000C.
- Wait states and stall: hold READY=0 for 3 cycles → REQ=1 and ADDR stable throughout, INSTR_VALID=0. Then assert STALL for 2 EXEC cycles → INSTR_VALID high 3 cycles, INSTR/PC unchanged, exactly one PC update.
- Wrap-around: PC=0xFFFFFFFC, sequential instruction → next IMEM_ADDR=0x00000000.
- Reset mid-FETCH: drop RST_N while REQ=1 and READY=0 → IMEM_REQ=0 within the same cycle, PC=RESET_PC, INSTR=0, INSTR_VALID=0. Normal restart follows after release.
